matrix_feeder: RTL

MATRIX_FEEDER -- requirements
Module: matrix_feeder

---
 rtl/matrix_pkg.sv | 39 +++
 rtl/matrix_feeder_if.sv | 56 +++++
 rtl/matrix_feeder_skew_line.sv | 59 +++++
 rtl/matrix_feeder.sv | 128 ++++++++++++
 4 files changed

// File: rtl/matrix_pkg.sv
// ---------------------------------------------------------------------------
// matrix_pkg
// Shared constants, FSM state encoding and address helper for the matrix
// feeder. Imported by the interface, the skew line and the top.
// ---------------------------------------------------------------------------
package matrix_pkg;

  localparam int DIM    = 4;
  localparam int WORD_W = 16;
  localparam int ADDR_W = 16;
  localparam int CNT_W  = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_e;

  // Address of element k for lane `lane`. In row mode the lane selects the
  // row and k walks the columns; in column mode the roles swap. The sum is
  // truncated to ADDR_W bits so it wraps silently past the top of memory.
  function automatic logic [ADDR_W-1:0] elem_addr(
    input logic [ADDR_W-1:0] base,
    input logic [CNT_W-1:0]  lane,
    input logic [CNT_W-1:0]  k,
    input logic              col_mode,
    input int                stride
  );
    logic [31:0] major;
    logic [31:0] minor;
    logic [31:0] sum;
    major = col_mode ? 32'(k) : 32'(lane);
    minor = col_mode ? 32'(lane) : 32'(k);
    sum   = 32'(base) + major * 32'(stride) + minor;
    return sum[ADDR_W-1:0];
  endfunction

endpackage

// File: rtl/matrix_feeder_if.sv
// ---------------------------------------------------------------------------
// matrix_feeder_if
// Bundles the control request, the 4-port memory read bus and the skewed
// lane outputs of the matrix feeder.
//   slave  : the feeder (takes start/base/col_mode and read data, drives
//            addresses, lane streams, busy/done and the state debug view)
//   master : the controller/memory side (the reverse directions)
// Handshake: start is a single-cycle request honoured only while busy is
// low; there is no backpressure on the lane streams -- lane_valid[r]
// qualifies lane_data r in the cycle it is high, and done pulses for one
// cycle when the whole matrix has left the delay lines.
// ---------------------------------------------------------------------------
interface matrix_feeder_if;
  import matrix_pkg::*;

  logic              start;
  logic [ADDR_W-1:0] base_addr;
  logic              col_mode;

  logic [ADDR_W-1:0] addr_out1;
  logic [ADDR_W-1:0] addr_out2;
  logic [ADDR_W-1:0] addr_out3;
  logic [ADDR_W-1:0] addr_out4;

  logic [WORD_W-1:0] data_in1;
  logic [WORD_W-1:0] data_in2;
  logic [WORD_W-1:0] data_in3;
  logic [WORD_W-1:0] data_in4;

  logic [WORD_W-1:0] lane_data0;
  logic [WORD_W-1:0] lane_data1;
  logic [WORD_W-1:0] lane_data2;
  logic [WORD_W-1:0] lane_data3;
  logic [DIM-1:0]    lane_valid;

  logic              busy;
  logic              done;
  state_e            state_dbg;

  modport slave (
    input  start, base_addr, col_mode,
    input  data_in1, data_in2, data_in3, data_in4,
    output addr_out1, addr_out2, addr_out3, addr_out4,
    output lane_data0, lane_data1, lane_data2, lane_data3, lane_valid,
    output busy, done, state_dbg
  );

  modport master (
    output start, base_addr, col_mode,
    output data_in1, data_in2, data_in3, data_in4,
    input  addr_out1, addr_out2, addr_out3, addr_out4,
    input  lane_data0, lane_data1, lane_data2, lane_data3, lane_valid,
    input  busy, done, state_dbg
  );

endinterface

// File: rtl/matrix_feeder_skew_line.sv
// ---------------------------------------------------------------------------
// skew_line
// DEPTH-stage shift register carrying a data word plus a valid bit. Shifts
// only when shift_en is high. Invalid entries are stored as zero and the
// output is additionally gated by valid so bubbles always read as 0x0000.
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   shift_en          advance the line by one stage
//   in_valid, in_data entry written into stage 0 on a shift
//   out_valid, out_data last stage
// ---------------------------------------------------------------------------
module skew_line
  import matrix_pkg::*;
#(
  parameter int DEPTH = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              shift_en,
  input  logic              in_valid,
  input  logic [WORD_W-1:0] in_data,
  output logic              out_valid,
  output logic [WORD_W-1:0] out_data
);

  logic [WORD_W-1:0] data_q [DEPTH];
  logic [WORD_W-1:0] data_d [DEPTH];
  logic [DEPTH-1:0]  valid_q;
  logic [DEPTH-1:0]  valid_d;

  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    if (shift_en) begin
      data_d[0]  = in_valid ? in_data : '0;
      valid_d[0] = in_valid;
      for (int i = 1; i < DEPTH; i++) begin
        data_d[i]  = data_q[i-1];
        valid_d[i] = valid_q[i-1];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        data_q[i] <= '0;
      end
      valid_q <= '0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
    end
  end

  assign out_valid = valid_q[DEPTH-1];
  assign out_data  = valid_q[DEPTH-1] ? data_q[DEPTH-1] : '0;

endmodule

// File: rtl/matrix_feeder.sv
// ---------------------------------------------------------------------------
// matrix_feeder
// Streams one 4x4 matrix of 16-bit words from a 4-port memory into the edge
// of a systolic array. Lane r reads row r (col_mode=0) or column r
// (col_mode=1); lane r is delayed by r+1 register stages so the lanes
// arrive skewed by one cycle each.
// Sequence: IDLE -start-> FETCH (4 cycles, one element per lane per cycle)
//           -> DRAIN (4 cycles, lines flush with zero bubbles)
//           -> DONE (1 cycle, done pulse) -> IDLE.
// Ports:
//   clk  clock
//   rst  asynchronous active-high reset
//   bus  matrix_feeder_if.slave (request, memory bus, lane streams, status)
// Parameter:
//   ROW_STRIDE  address distance between consecutive rows (words)
// ---------------------------------------------------------------------------
module matrix_feeder
  import matrix_pkg::*;
#(
  parameter int ROW_STRIDE = 4
) (
  input  logic     clk,
  input  logic     rst,
  matrix_feeder_if.slave bus
);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  k_q, k_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic              col_q, col_d;

  logic              fetch_active;
  logic              shift_en;
  logic [ADDR_W-1:0] addr     [DIM];
  logic [WORD_W-1:0] din      [DIM];
  logic [WORD_W-1:0] lane_out [DIM];
  logic [DIM-1:0]    lane_vld;

  // Next-state and datapath registers. k counts 0..3 in both FETCH and
  // DRAIN and wraps back to 0 on the phase change, so no explicit clear is
  // needed between the two phases.
  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    base_d  = base_q;
    col_d   = col_q;
    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d = FETCH;
          k_d     = '0;
          base_d  = bus.base_addr;
          col_d   = bus.col_mode;
        end
      end
      FETCH: begin
        k_d = k_q + 1'b1;
        if (k_q == CNT_W'(DIM - 1)) state_d = DRAIN;
      end
      DRAIN: begin
        k_d = k_q + 1'b1;
        if (k_q == CNT_W'(DIM - 1)) state_d = DONE;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      k_q     <= '0;
      base_q  <= '0;
      col_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      base_q  <= base_d;
      col_q   <= col_d;
    end
  end

  assign fetch_active = (state_q == FETCH);
  assign shift_en     = (state_q == FETCH) || (state_q == DRAIN);

  // Addresses are only meaningful while fetching; hold them at zero
  // otherwise so the memory sees a quiet bus.
  always_comb begin
    for (int r = 0; r < DIM; r++) begin
      addr[r] = fetch_active ? elem_addr(base_q, CNT_W'(r), k_q, col_q, ROW_STRIDE) : '0;
    end
  end

  assign din[0] = bus.data_in1;
  assign din[1] = bus.data_in2;
  assign din[2] = bus.data_in3;
  assign din[3] = bus.data_in4;

  // Lane r gets r+1 stages: stage 0 captures the read data on the fetch
  // edge and the extra r stages produce the diagonal skew.
  for (genvar r = 0; r < DIM; r++) begin : g_lane
    skew_line #(.DEPTH(r + 1)) u_skew (
      .clk      (clk),
      .rst      (rst),
      .shift_en (shift_en),
      .in_valid (fetch_active),
      .in_data  (din[r]),
      .out_valid(lane_vld[r]),
      .out_data (lane_out[r])
    );
  end

  assign bus.addr_out1  = addr[0];
  assign bus.addr_out2  = addr[1];
  assign bus.addr_out3  = addr[2];
  assign bus.addr_out4  = addr[3];
  assign bus.lane_data0 = lane_out[0];
  assign bus.lane_data1 = lane_out[1];
  assign bus.lane_data2 = lane_out[2];
  assign bus.lane_data3 = lane_out[3];
  assign bus.lane_valid = lane_vld;
  assign bus.busy       = (state_q != IDLE);
  assign bus.done       = (state_q == DONE);
  assign bus.state_dbg  = state_q;

endmodule
